cnt_regbank: RTL and testbench
==============================

# cnt_regbank

Parametrised control/status register bank for the multi-channel counter subsystem, sitting between the single-port host bus (cs/rw/addr/wdata) and N8 8-bit loadable counters plus N32 32-bit free-running counters. It generalises the fixed 6+4-channel register file:

- Channel counts are parameters.
- Byte-enable writes.
- Self-clearing load/clear pulses.
- Coherent snapshot of 32-bit counters.
- Registered read with valid strobe.
- Error flag for illegal accesses.

## Interface
Parameters:
- N8, 6, number of 8-bit counter channels (1..32)
- N32, 4, number of 32-bit counter channels (1..16)

Ports:
- clk  in  1  system clock, all logic on rising edge
- xrst  in  1  synchronous, active-high reset
- cs  in  1  access request, one access per cycle when high
- rw  in  1  1 = write, 0 = read
- addr  in  8  word address
- wdata  in  32  write data
- be  in  4  byte enables for writes; be[i] qualifies wdata[8i+7:8i]
- rdata  out  32  read data, registered
- rvalid  out  1  one-cycle strobe, rdata valid
- err  out  1  one-cycle strobe, illegal access
- en8  out  N8  8-bit counter enables
- ld8  out  N8  one-cycle load pulses
- val8  out  8*N8  load values, channel k at [8k+7:8k]
- cnt8  in  8*N8  live 8-bit counts
- en32  out  N32  32-bit counter enables
- clr32  out  N32  one-cycle clear pulses
- cnt32  in  32*N32  live 32-bit counts

## Operation
Address map:
- 0x00 EN8, R/W, bits [N8-1:0].
- 0x01 LD8, W1P: writing 1 to bit k pulses ld8[k]. Reads 0.
- 0x02 EN32, R/W, bits [N32-1:0].
- 0x03 CLR32, W1P: writing 1 to bit k pulses clr32[k]. Reads 0.
- 0x04 SNAP, WO: any write with be!=0 copies all cnt32 into shadow registers in one cycle.
- 0x08+w VAL8 word w, R/W, w = 0..ceil(N8/4)-1. Byte i of the word is channel 4w+i.
- 0x10+w CNT8 word w, RO, live cnt8 packed the same way as VAL8.
- 0x20+j CNT32 shadow j, RO, j = 0..N32-1.

Write rules:
- A write is accepted when cs&rw.
- R/W registers update only the bytes with be set.
- Bits and bytes at or above the channel count are not stored and read 0.
- W1P registers pulse only for bits inside enabled bytes.

err pulses for any of:
- a write to an RO or unmapped address;
- a read of a WO or unmapped address (this includes SNAP);
- a write with be=0.

On an erroring access, no state changes. A read of a W1P address is legal and returns 0.

## Timing
- Reset (xrst=1 at a clock edge) sets all of the following to 0: en8, ld8, val8, en32, clr32, rdata, rvalid, err, and all shadows.
- Reset cancels any pending pulse and takes priority over a simultaneous access.
- Write to an R/W register: the output changes on the edge that accepts the write, so it is visible in the next cycle.
- ld8 and clr32: registered, high for exactly the cycle after the write, then cleared. Back-to-back writes give back-to-back pulses.
- SNAP: shadows update on the accepting edge. A CNT32 read in the next cycle returns the value captured at that edge.
- Read: rdata and rvalid appear one cycle after the cs&~rw cycle. rdata holds its value until the next valid read. Illegal reads give rvalid=0 and err=1, and rdata is unchanged.
- err: issued one cycle after the offending access.
- Throughput: one access per cycle. There is no backpressure.
- CNT8 reads sample the live input at the request edge.
- CNT32 reads return the shadow value, never the live count.

## Test plan
- Reset, then read 0x00, 0x02, 0x08, 0x20 → each returns 0 with rvalid one cycle after the request; all outputs are 0.
- Write 0x08 = 0xAABBCCDD with be=4'b0101 → val8[0]=0xDD, val8[2]=0xBB, channels 1 and 3 stay 0; readback gives 0x00BB00DD.
- Write 0x01 = 0x21 (N8=6) → ld8[0] and ld8[5] are high for exactly one cycle, the next cycle after the write. A read of 0x01 returns 0.
- cnt32[0] counts up each cycle; write SNAP at count 100 → reading 0x20 later returns 100 regardless of the live value. A second SNAP then updates it.
- Write 0x10, read 0x04, read 0x3F, write 0x00 with be=0 → err pulses on each, rvalid stays 0, and no register changes.
- Assert xrst during a LD8 write cycle → no ld8 pulse follows, and EN/VAL registers read 0.

Source files
------------

// File: rtl/cnt_regbank_if.sv
// Host bus between the CPU-side master and the counter register bank.
// One access per cycle on cs; read data and status come back one cycle later.
interface cnt_regbank_if;
    logic        cs;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (output cs, rw, addr, wdata, be, input rdata, rvalid, err);
    modport slave  (input cs, rw, addr, wdata, be, output rdata, rvalid, err);
endinterface

// File: rtl/cnt_regbank.sv
// Control/status register bank for N8 8-bit loadable and N32 32-bit free-running
// counters: byte-enable writes, load/clear pulses, coherent 32-bit snapshot, registered reads.
module cnt_regbank #(
    parameter int N8  = 6,
    parameter int N32 = 4
) (
    input  logic              clk,
    input  logic              xrst,
    cnt_regbank_if.slave      bus,
    output logic [N8-1:0]     en8,
    output logic [N8-1:0]     ld8,
    output logic [8*N8-1:0]   val8,
    input  logic [8*N8-1:0]   cnt8,
    output logic [N32-1:0]    en32,
    output logic [N32-1:0]    clr32,
    input  logic [32*N32-1:0] cnt32
);
    localparam int N8W = (N8 + 3) / 4;

    localparam logic [7:0] ADDR_EN8   = 8'h00;
    localparam logic [7:0] ADDR_LD8   = 8'h01;
    localparam logic [7:0] ADDR_EN32  = 8'h02;
    localparam logic [7:0] ADDR_CLR32 = 8'h03;
    localparam logic [7:0] ADDR_SNAP  = 8'h04;

    logic [N8-1:0]      en8_q, en8_d, ld8_q, ld8_d;
    logic [8*N8-1:0]    val8_q, val8_d;
    logic [N32-1:0]     en32_q, en32_d, clr32_q, clr32_d;
    logic [32*N32-1:0]  shadow_q;
    logic [31:0]        rdata_q, rd_val, bmask;
    logic               rvalid_q, err_q;
    logic [32*N8W-1:0]  val8_pad, cnt8_pad;
    logic               wr_ok, rd_ok, acc_wr, acc_rd, bad, snap;
    int                 vw, sj;

    assign bmask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
    assign vw    = int'(bus.addr[2:0]);
    assign sj    = int'(bus.addr[3:0]);

    // Words are padded to whole 32-bit words; bytes past the last channel read 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        val8_pad = '0;
        cnt8_pad = '0;
        val8_pad[8*N8-1:0] = val8_q;
        cnt8_pad[8*N8-1:0] = cnt8;
    end

    always_comb begin
        wr_ok  = 1'b0;
        rd_ok  = 1'b0;
        rd_val = '0;
        if (bus.addr == ADDR_EN8) begin
            wr_ok = 1'b1;
            rd_ok = 1'b1;
            rd_val[N8-1:0] = en8_q;
        end else if (bus.addr == ADDR_LD8 || bus.addr == ADDR_CLR32) begin
            wr_ok = 1'b1;
            rd_ok = 1'b1;
        end else if (bus.addr == ADDR_EN32) begin
            wr_ok = 1'b1;
            rd_ok = 1'b1;
            rd_val[N32-1:0] = en32_q;
        end else if (bus.addr == ADDR_SNAP) begin
            wr_ok = 1'b1;
        end else if (bus.addr[7:3] == 5'h01 && vw < N8W) begin
            wr_ok  = 1'b1;
            rd_ok  = 1'b1;
            rd_val = val8_pad[32*vw +: 32];
        end else if (bus.addr[7:3] == 5'h02 && vw < N8W) begin
            rd_ok  = 1'b1;
            rd_val = cnt8_pad[32*vw +: 32];
        end else if (bus.addr[7:4] == 4'h2 && sj < N32) begin
            rd_ok  = 1'b1;
            rd_val = shadow_q[32*sj +: 32];
        end
    end

    assign acc_wr = bus.cs & bus.rw & wr_ok & (bus.be != 4'b0000);
    assign acc_rd = bus.cs & ~bus.rw & rd_ok;
    assign bad    = bus.cs & ~acc_wr & ~acc_rd;

    always_comb begin
        en8_d   = en8_q;
        val8_d  = val8_q;
        en32_d  = en32_q;
        ld8_d   = '0;
        clr32_d = '0;
        snap    = 1'b0;
        if (acc_wr) begin
            if (bus.addr == ADDR_EN8)
                en8_d = (en8_q & ~bmask[N8-1:0]) | (bus.wdata[N8-1:0] & bmask[N8-1:0]);
            else if (bus.addr == ADDR_LD8)
                ld8_d = bus.wdata[N8-1:0] & bmask[N8-1:0];
            else if (bus.addr == ADDR_EN32)
                en32_d = (en32_q & ~bmask[N32-1:0]) | (bus.wdata[N32-1:0] & bmask[N32-1:0]);
            else if (bus.addr == ADDR_CLR32)
                clr32_d = bus.wdata[N32-1:0] & bmask[N32-1:0];
            else if (bus.addr == ADDR_SNAP)
                snap = 1'b1;
            else
                for (int i = 0; i < 4; i++)
                    if (4*vw + i < N8 && bus.be[i])
                        val8_d[8*(4*vw + i) +: 8] = bus.wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (xrst) begin
            en8_q    <= '0;
            ld8_q    <= '0;
            val8_q   <= '0;
            en32_q   <= '0;
            clr32_q  <= '0;
            // NOTE: the shadow bank is small and must read 0 after reset, so it is reset like any register.
            shadow_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            en8_q    <= en8_d;
            ld8_q    <= ld8_d;
            val8_q   <= val8_d;
            en32_q   <= en32_d;
            clr32_q  <= clr32_d;
            rvalid_q <= acc_rd;
            err_q    <= bad;
            if (snap)
                shadow_q <= cnt32;
            if (acc_rd)
                rdata_q <= rd_val;
        end
    end

    assign en8        = en8_q;
    assign ld8        = ld8_q;
    assign val8       = val8_q;
    assign en32       = en32_q;
    assign clr32      = clr32_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_cnt_regbank.sv
// Directed self-checking bench for cnt_regbank with N8=6, N32=4.
module tb_cnt_regbank;
    localparam int N8  = 6;
    localparam int N32 = 4;

    logic              clk;
    logic              xrst;
    logic [N8-1:0]     en8, ld8;
    logic [8*N8-1:0]   val8;
    logic [8*N8-1:0]   cnt8;
    logic [N32-1:0]    en32, clr32;
    logic [32*N32-1:0] cnt32;
    logic [31:0]       cnt0;
    logic [31:0]       rd_d, exp_snap;
    logic              rd_v, rd_e;
    int                n_cmp, n_bad, guard;

    cnt_regbank_if bus ();

    cnt_regbank #(.N8(N8), .N32(N32)) dut (
        .clk   (clk),
        .xrst  (xrst),
        .bus   (bus),
        .en8   (en8),
        .ld8   (ld8),
        .val8  (val8),
        .cnt8  (cnt8),
        .en32  (en32),
        .clr32 (clr32),
        .cnt32 (cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel 0 of the 32-bit counters free-runs; channel 1 is a fixed pattern.
    always @(posedge clk)
        if (xrst) cnt0 <= '0;
        else      cnt0 <= cnt0 + 32'd1;
    assign cnt32 = {32'h0, 32'h0, 32'hDEADBEEF, cnt0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.wdata = d; bus.be = b;
        @(posedge clk); #1;
        bus.cs = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic v, output logic e);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.wdata = '0; bus.be = 4'h0;
        @(posedge clk); #1;
        bus.cs = 1'b0;
        d = bus.rdata; v = bus.rvalid; e = bus.err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        bus.cs = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
        cnt8 = 48'h6050_4030_2010;
        xrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {en8, ld8, val8, en32, clr32}, '0);
        check("rst_status", {bus.rdata, bus.rvalid, bus.err}, '0);
        xrst = 1'b0;
        idle();

        // Reset values read back as 0 with a one-cycle rvalid strobe.
        bus_read(8'h00, rd_d, rd_v, rd_e); check("rd_en8_rst", {rd_d, rd_v, rd_e}, {32'h0, 2'b10});
        bus_read(8'h02, rd_d, rd_v, rd_e); check("rd_en32_rst", {rd_d, rd_v, rd_e}, {32'h0, 2'b10});
        bus_read(8'h08, rd_d, rd_v, rd_e); check("rd_val8_rst", {rd_d, rd_v, rd_e}, {32'h0, 2'b10});
        bus_read(8'h20, rd_d, rd_v, rd_e); check("rd_shd_rst", {rd_d, rd_v, rd_e}, {32'h0, 2'b10});
        idle();
        check("rvalid_strobe", bus.rvalid, 1'b0);

        // Byte-enabled VAL8 writes, including the partially populated word.
        bus_write(8'h08, 32'hAABBCCDD, 4'b0101);
        check("val8_be", val8, 48'h0000_00BB_00DD);
        bus_write(8'h09, 32'hFFFFFFFF, 4'b1111);
        check("val8_top", val8, 48'hFFFF_00BB_00DD);
        bus_read(8'h08, rd_d, rd_v, rd_e); check("rd_val8_w0", {rd_d, rd_v}, {32'h00BB00DD, 1'b1});
        bus_read(8'h09, rd_d, rd_v, rd_e); check("rd_val8_w1", {rd_d, rd_v}, {32'h0000FFFF, 1'b1});

        // Enable registers keep only bits below the channel count.
        bus_write(8'h00, 32'h0000FFFF, 4'b0001);
        check("en8_wr", en8, 6'h3F);
        bus_write(8'h02, 32'hFFFFFFFF, 4'b0001);
        check("en32_wr", en32, 4'hF);
        bus_read(8'h00, rd_d, rd_v, rd_e); check("rd_en8", rd_d, 32'h0000003F);
        bus_read(8'h02, rd_d, rd_v, rd_e); check("rd_en32", rd_d, 32'h0000000F);
        idle();

        // W1P pulses: exactly one cycle, back-to-back when written back-to-back.
        bus_write(8'h01, 32'h00000021, 4'b0001);
        check("ld8_pulse", ld8, 6'b100001);
        idle();
        check("ld8_clear", ld8, 6'b000000);
        bus_write(8'h01, 32'h00000001, 4'b0001);
        check("ld8_b2b_0", ld8, 6'b000001);
        bus_write(8'h01, 32'h00000002, 4'b0001);
        check("ld8_b2b_1", ld8, 6'b000010);
        bus_write(8'h01, 32'h0000003F, 4'b0010);
        check("ld8_be_mask", ld8, 6'b000000);
        bus_read(8'h01, rd_d, rd_v, rd_e); check("rd_ld8_zero", {rd_d, rd_v, rd_e}, {32'h0, 2'b10});
        bus_write(8'h03, 32'h00000005, 4'b0001);
        check("clr32_pulse", clr32, 4'b0101);
        idle();
        check("clr32_clear", clr32, 4'b0000);

        // CNT8 reads sample the live input.
        bus_read(8'h10, rd_d, rd_v, rd_e); check("rd_cnt8_w0", rd_d, 32'h40302010);
        bus_read(8'h11, rd_d, rd_v, rd_e); check("rd_cnt8_w1", rd_d, 32'h00006050);

        // Snapshot the free-running counter at exactly 100.
        guard = 0;
        while (cnt0 != 32'd100 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("cnt0_reach_100", cnt0, 32'd100);
        bus_write(8'h04, 32'h00000001, 4'b0001);
        repeat (5) idle();
        bus_read(8'h20, rd_d, rd_v, rd_e); check("rd_snap0", {rd_d, rd_v}, {32'd100, 1'b1});
        bus_read(8'h21, rd_d, rd_v, rd_e); check("rd_snap1", rd_d, 32'hDEADBEEF);
        exp_snap = cnt0;
        bus_write(8'h04, 32'h00000000, 4'b1000);
        bus_read(8'h20, rd_d, rd_v, rd_e); check("rd_snap0_again", rd_d, exp_snap);
        bus_read(8'h11, rd_d, rd_v, rd_e); check("rd_cnt8_last", rd_d, 32'h00006050);

        // Illegal accesses: err strobe, no rvalid, rdata held, no state change.
        bus_write(8'h10, 32'hFFFFFFFF, 4'b1111);
        check("err_wr_ro", {bus.err, bus.rvalid}, 2'b10);
        bus_read(8'h04, rd_d, rd_v, rd_e); check("err_rd_snap", {rd_d, rd_v, rd_e}, {32'h00006050, 2'b01});
        bus_read(8'h3F, rd_d, rd_v, rd_e); check("err_rd_unmap", {rd_d, rd_v, rd_e}, {32'h00006050, 2'b01});
        bus_read(8'h0A, rd_d, rd_v, rd_e); check("err_rd_val8_oor", {rd_v, rd_e}, 2'b01);
        bus_read(8'h24, rd_d, rd_v, rd_e); check("err_rd_shd_oor", {rd_v, rd_e}, 2'b01);
        bus_write(8'h00, 32'h00000000, 4'b0000);
        check("err_be0", {bus.err, en8}, {1'b1, 6'h3F});
        bus_write(8'h04, 32'h00000000, 4'b0000);
        check("err_snap_be0", bus.err, 1'b1);
        idle();
        check("err_strobe", bus.err, 1'b0);
        bus_read(8'h00, rd_d, rd_v, rd_e); check("en8_kept", {rd_d, rd_v, rd_e}, {32'h3F, 2'b10});
        bus_read(8'h20, rd_d, rd_v, rd_e); check("snap_kept", rd_d, exp_snap);
        check("val8_kept", val8, 48'hFFFF_00BB_00DD);

        // Reset during an LD8 write wins: no pulse, registers cleared.
        xrst = 1'b1;
        bus_write(8'h01, 32'h0000003F, 4'b0001);
        check("rst_ld8_cancel", ld8, 6'b000000);
        xrst = 1'b0;
        idle();
        check("rst_ld8_none", ld8, 6'b000000);
        bus_read(8'h00, rd_d, rd_v, rd_e); check("rst_rd_en8", {rd_d, rd_v}, {32'h0, 1'b1});
        bus_read(8'h02, rd_d, rd_v, rd_e); check("rst_rd_en32", {rd_d, rd_v}, {32'h0, 1'b1});
        bus_read(8'h09, rd_d, rd_v, rd_e); check("rst_rd_val8", {rd_d, rd_v}, {32'h0, 1'b1});
        bus_read(8'h20, rd_d, rd_v, rd_e); check("rst_rd_shd", {rd_d, rd_v}, {32'h0, 1'b1});
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
